spi_adc_sampler: RTL

//  Parametrised SPI master for the serial ADC front end. Generates spi_clock and spi_chipselect,

---
 rtl/spi_adc_sampler.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/spi_adc_sampler.sv
// SPI master for the serial ADC: one SAMPLE_WIDTH-bit word per frame, MSB first, channels scanned round-robin.
// Latency: the word is on out_data the cycle after chip select rises; frame = CLOCK_DIVIDE*(1+2*SAMPLE_WIDTH)+GAP_CYCLES.
// Backpressure: one-deep output register; a word that completes while it is still full is dropped and overrun pulses.
// Optional: SPI_ADC_SAMPLER_CHAN_ADDR_EN drives the next channel address on spi_mosi (needs SAMPLE_WIDTH>=5).
module spi_adc_sampler #(
    parameter int SAMPLE_WIDTH  = 16,
    parameter int CLOCK_DIVIDE  = 4,
    parameter int GAP_CYCLES    = 4,
    parameter int CHANNEL_TOTAL = 1,
    parameter int CHANNEL_WIDTH = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    output logic                     spi_clock,
    output logic                     spi_chipselect,
    input  logic                     spi_data,
    output logic                     spi_mosi,
    output logic [SAMPLE_WIDTH-1:0]  out_data,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overrun,
    output logic                     busy
);

    localparam int PHASE_MAX = (CLOCK_DIVIDE > GAP_CYCLES) ? CLOCK_DIVIDE : GAP_CYCLES;
    localparam int CNT_W     = $clog2(PHASE_MAX + 1);
    localparam int BIT_W     = $clog2(SAMPLE_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_GAP
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         phase_cnt;
    logic [CNT_W-1:0]         phase_nxt;
    logic [BIT_W-1:0]         bit_cnt;
    logic [BIT_W-1:0]         bit_nxt;
    logic [SAMPLE_WIDTH-1:0]  shift_reg;
    logic [CHANNEL_WIDTH-1:0] chan_cnt;
    logic [CHANNEL_WIDTH-1:0] chan_next;
    logic                     phase_done;
    logic                     last_bit;
    logic                     capture;
    logic                     commit;

    assign phase_done = (phase_cnt == '0);
    assign last_bit   = (bit_cnt == BIT_W'(SAMPLE_WIDTH - 1));
    // Sample on the cycle sclk rises; commit on the cycle chip select rises.
    assign capture    = (state == S_LOW) && phase_done;
    assign commit     = (state == S_HIGH) && phase_done && last_bit;
    assign chan_next  = (chan_cnt == CHANNEL_WIDTH'(CHANNEL_TOTAL - 1)) ? '0
                                                                       : chan_cnt + CHANNEL_WIDTH'(1);

    assign spi_chipselect = (state == S_IDLE) || (state == S_GAP);
    assign spi_clock      = (state != S_LOW);
    assign busy           = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            bit_cnt   <= bit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase_cnt - CNT_W'(1);
        bit_nxt   = bit_cnt;
        case (state)
            S_IDLE: begin
                phase_nxt = phase_cnt;
                if (enable) begin
                    state_nxt = S_SETUP;
                    phase_nxt = CNT_W'(CLOCK_DIVIDE - 1);
                    bit_nxt   = '0;
                end
            end
            S_SETUP: begin
                if (phase_done) begin
                    state_nxt = S_LOW;
                    phase_nxt = CNT_W'(CLOCK_DIVIDE - 1);
                end
            end
            S_LOW: begin
                if (phase_done) begin
                    state_nxt = S_HIGH;
                    phase_nxt = CNT_W'(CLOCK_DIVIDE - 1);
                end
            end
            S_HIGH: begin
                if (phase_done) begin
                    if (last_bit) begin
                        state_nxt = S_GAP;
                        phase_nxt = CNT_W'(GAP_CYCLES - 1);
                    end else begin
                        state_nxt = S_LOW;
                        phase_nxt = CNT_W'(CLOCK_DIVIDE - 1);
                        bit_nxt   = bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (phase_done) begin
                    bit_nxt = '0;
                    if (enable) begin
                        state_nxt = S_SETUP;
                        phase_nxt = CNT_W'(CLOCK_DIVIDE - 1);
                    end else begin
                        state_nxt = S_IDLE;
                        phase_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                phase_nxt = '0;
                bit_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_reg   <= '0;
            chan_cnt    <= '0;
            out_data    <= '0;
            out_channel <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (capture) begin
                shift_reg <= {shift_reg[SAMPLE_WIDTH-2:0], spi_data};
            end
            if (commit) begin
                // The channel advances even when the word is dropped, so tags stay aligned to the scan.
                chan_cnt <= chan_next;
                if (!out_valid || out_ready) begin
                    out_data    <= shift_reg;
                    out_channel <= chan_cnt;
                    out_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SPI_ADC_SAMPLER_CHAN_ADDR_EN
    logic [SAMPLE_WIDTH-1:0] cmd_sr;
    logic [2:0]              next_ch3;
    logic                    mosi_q;
    logic                    enter_setup;
    logic                    enter_low;

    assign next_ch3    = 3'(chan_next);
    assign enter_setup = (state_nxt == S_SETUP) && (state != S_SETUP);
    assign enter_low   = (state_nxt == S_LOW) && (state != S_LOW);

    // The address sent in this frame selects the channel the ADC converts in the next one.
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_sr <= '0;
            mosi_q <= 1'b0;
        end else if (enter_setup) begin
            cmd_sr <= SAMPLE_WIDTH'({2'b00, next_ch3}) << (SAMPLE_WIDTH - 5);
            mosi_q <= 1'b0;
        end else if (enter_low) begin
            mosi_q <= cmd_sr[SAMPLE_WIDTH-1];
            cmd_sr <= {cmd_sr[SAMPLE_WIDTH-2:0], 1'b0};
        end else if (commit) begin
            mosi_q <= 1'b0;
        end
    end

    assign spi_mosi = mosi_q;
`else
    assign spi_mosi = 1'b0;
`endif

endmodule
